// File: rtl/dti_pkg.sv
// Shared helpers for dti channel blocks: pointer width and DEPTH legality check.
package dti_pkg;

  // Index bits plus one wrap bit.
  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/dti_if.sv
// dti valid/ready channel. A word transfers on a rising edge where valid && ready;
// once valid is raised, valid and data hold until that transfer, and ready never
// waits on valid.
interface dti #(
  parameter int W_DATA = 16
);
  logic [W_DATA-1:0] data;
  logic              valid;
  logic              ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dti_decouple_mem.sv
// Register-array storage for dti_decouple: one write port, one asynchronous read port.
module dti_decouple_mem #(
  parameter int W_DATA = 16,
  parameter int DEPTH  = 2,
  parameter int AW     = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [W_DATA-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [W_DATA-1:0] rdata
);

  logic [W_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dti_decouple.sv
// Registered FIFO stage cutting all combinational paths between two dti channels.
// Optional occupancy output `level` is enabled with DTI_DECOUPLE_LEVEL_EN.
module dti_decouple
  import dti_pkg::*;
#(
  parameter int W_DATA = 16,
  parameter int DEPTH  = 2
) (
  input  logic clk,
  input  logic rst_n,
  dti.consumer din,
  dti.producer dout
`ifdef DTI_DECOUPLE_LEVEL_EN
  ,
  output logic [ptr_w(DEPTH)-1:0] level
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if (!depth_ok(DEPTH)) begin : g_depth_check
    $error("dti_decouple: DEPTH=%0d must be a power of two and at least 2", DEPTH);
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          in_ready;
  logic          out_valid;
  logic          wr_en;
  logic          rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // No pass-through when full and no bypass when empty: both sides see flops only.
  assign in_ready  = rst_n && !full;
  assign out_valid = !empty;
  assign wr_en     = din.valid && in_ready;
  assign rd_en     = out_valid && dout.ready;

  assign din.ready  = in_ready;
  assign dout.valid = out_valid;

  // Pointers wrap modulo 2*DEPTH by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  dti_decouple_mem #(
    .W_DATA (W_DATA),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din.data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout.data)
  );

`ifdef DTI_DECOUPLE_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_dti_decouple.sv
// Directed and randomized checks of dti_decouple with DEPTH=4, W_DATA=16.
module tb_dti_decouple;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [15:0] exp_q[$];

  dti #(.W_DATA(16)) din_if ();
  dti #(.W_DATA(16)) dout_if ();

`ifdef DTI_DECOUPLE_LEVEL_EN
  logic [2:0] level;
`endif

  dti_decouple #(
    .W_DATA (16),
    .DEPTH  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din_if),
    .dout  (dout_if)
`ifdef DTI_DECOUPLE_LEVEL_EN
    ,
    .level (level)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din_if.valid = 1'b0;
    din_if.data = '0;
    dout_if.ready = 1'b0;
    #1;
    repeat (3) begin
      n_vec++;
      if (din_if.ready !== 1'b0) begin
        n_err++; $display("FAIL reset_in_ready: got %b expected 0", din_if.ready);
      end
      n_vec++;
      if (dout_if.valid !== 1'b0) begin
        n_err++; $display("FAIL reset_out_valid: got %b expected 0", dout_if.valid);
      end
      step();
    end
    rst_n = 1'b1;
    step();
    n_vec++;
    if (din_if.ready !== 1'b1) begin
      n_err++; $display("FAIL idle_in_ready: got %b expected 1", din_if.ready);
    end
    n_vec++;
    if (dout_if.valid !== 1'b0) begin
      n_err++; $display("FAIL idle_out_valid: got %b expected 0", dout_if.valid);
    end
`ifdef DTI_DECOUPLE_LEVEL_EN
    n_vec++;
    if (level !== 3'd0) begin
      n_err++; $display("FAIL idle_level: got %0d expected 0", level);
    end
`endif
  endtask

  task automatic test_fill();
    logic [15:0] words [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    dout_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (din_if.ready !== 1'b1) begin
        n_err++; $display("FAIL fill_ready_%0d: got %b expected 1", i, din_if.ready);
      end
      din_if.valid = 1'b1;
      din_if.data = words[i];
      step();
`ifdef DTI_DECOUPLE_LEVEL_EN
      n_vec++;
      if (level !== 3'(i + 1)) begin
        n_err++; $display("FAIL fill_level_%0d: got %0d expected %0d", i, level, i + 1);
      end
`endif
    end
    din_if.data = 16'h0055;
    repeat (2) begin
      n_vec++;
      if (din_if.ready !== 1'b0) begin
        n_err++; $display("FAIL full_ready: got %b expected 0", din_if.ready);
      end
      n_vec++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== 16'h0011) begin
        n_err++; $display("FAIL full_head: got %b/%h expected 1/0011", dout_if.valid, dout_if.data);
      end
      step();
    end
  endtask

  task automatic test_drain();
    logic [15:0] exp_data [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    logic        exp_rdy  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int          exp_lvl  [5] = '{4, 3, 3, 2, 1};
    dout_if.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_data[k]) begin
        n_err++; $display("FAIL drain_data_%0d: got %b/%h expected 1/%h", k, dout_if.valid, dout_if.data, exp_data[k]);
      end
      n_vec++;
      if (din_if.ready !== exp_rdy[k]) begin
        n_err++; $display("FAIL drain_ready_%0d: got %b expected %b", k, din_if.ready, exp_rdy[k]);
      end
`ifdef DTI_DECOUPLE_LEVEL_EN
      n_vec++;
      if (level !== 3'(exp_lvl[k])) begin
        n_err++; $display("FAIL drain_level_%0d: got %0d expected %0d", k, level, exp_lvl[k]);
      end
`endif
      if (din_if.valid && din_if.ready) begin
        step();
        din_if.valid = 1'b0;
      end else begin
        step();
      end
    end
    n_vec++;
    if (dout_if.valid !== 1'b0 || din_if.ready !== 1'b1) begin
      n_err++; $display("FAIL drain_empty: got valid=%b ready=%b expected 0/1", dout_if.valid, din_if.ready);
    end
  endtask

  task automatic test_stream();
    dout_if.ready = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      din_if.valid = (c < 100);
      din_if.data = 16'h0100 + 16'(c);
      n_vec++;
      if (din_if.ready !== 1'b1) begin
        n_err++; $display("FAIL stream_ready_%0d: got %b expected 1", c, din_if.ready);
      end
      n_vec++;
      if (c == 0) begin
        if (dout_if.valid !== 1'b0) begin
          n_err++; $display("FAIL stream_first: got valid %b expected 0", dout_if.valid);
        end
      end else if (dout_if.valid !== 1'b1 || dout_if.data !== 16'h0100 + 16'(c - 1)) begin
        n_err++; $display("FAIL stream_out_%0d: got %b/%h expected 1/%h", c, dout_if.valid, dout_if.data, 16'h0100 + 16'(c - 1));
      end
      step();
    end
    din_if.valid = 1'b0;
    n_vec++;
    if (dout_if.valid !== 1'b0) begin
      n_err++; $display("FAIL stream_end: got valid %b expected 0", dout_if.valid);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int got = 0;
    bit pending = 0;
    bit stalled = 0;
    logic [15:0] hold = '0;
    exp_q.delete();
    din_if.valid = 1'b0;
    dout_if.ready = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      if (stalled) begin
        n_vec++;
        if (dout_if.valid !== 1'b1 || dout_if.data !== hold) begin
          n_err++; $display("FAIL rand_stable: got %b/%h expected 1/%h", dout_if.valid, dout_if.data, hold);
        end
      end
`ifdef DTI_DECOUPLE_LEVEL_EN
      n_vec++;
      if (level !== 3'(exp_q.size())) begin
        n_err++; $display("FAIL rand_level: got %0d expected %0d", level, exp_q.size());
      end
`endif
      if (!pending) begin
        if (sent < 1000 && $urandom_range(0, 1) == 1) begin
          din_if.valid = 1'b1;
          din_if.data = 16'($urandom);
          pending = 1;
        end else begin
          din_if.valid = 1'b0;
        end
      end
      dout_if.ready = 1'($urandom_range(0, 1));
      if (din_if.valid && din_if.ready) begin
        exp_q.push_back(din_if.data);
        sent++;
        pending = 0;
      end
      if (dout_if.valid && dout_if.ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_spurious: got %h expected no word", dout_if.data);
        end else if (dout_if.data !== exp_q[0]) begin
          n_err++; $display("FAIL rand_data_%0d: got %h expected %h", got, dout_if.data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        got++;
      end
      stalled = dout_if.valid && !dout_if.ready;
      hold = dout_if.data;
      step();
    end
    din_if.valid = 1'b0;
    dout_if.ready = 1'b0;
    n_vec++;
    if (got != 1000) begin
      n_err++; $display("FAIL rand_timeout: got %0d words expected 1000", got);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] words [3] = '{16'h0001, 16'h0002, 16'h0003};
    dout_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din_if.valid = 1'b1;
      din_if.data = words[i];
      step();
    end
    din_if.valid = 1'b0;
    n_vec++;
    if (dout_if.valid !== 1'b1 || dout_if.data !== 16'h0001) begin
      n_err++; $display("FAIL mid_pre: got %b/%h expected 1/0001", dout_if.valid, dout_if.data);
    end
`ifdef DTI_DECOUPLE_LEVEL_EN
    n_vec++;
    if (level !== 3'd3) begin
      n_err++; $display("FAIL mid_pre_level: got %0d expected 3", level);
    end
`endif
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (dout_if.valid !== 1'b0 || din_if.ready !== 1'b0) begin
      n_err++; $display("FAIL mid_in_reset: got valid=%b ready=%b expected 0/0", dout_if.valid, din_if.ready);
    end
    #2 rst_n = 1'b1;
    #1;
    n_vec++;
    if (dout_if.valid !== 1'b0 || din_if.ready !== 1'b1) begin
      n_err++; $display("FAIL mid_released: got valid=%b ready=%b expected 0/1", dout_if.valid, din_if.ready);
    end
`ifdef DTI_DECOUPLE_LEVEL_EN
    n_vec++;
    if (level !== 3'd0) begin
      n_err++; $display("FAIL mid_level: got %0d expected 0", level);
    end
`endif
    din_if.valid = 1'b1;
    din_if.data = 16'h00AA;
    step();
    din_if.valid = 1'b0;
    n_vec++;
    if (dout_if.valid !== 1'b1 || dout_if.data !== 16'h00AA) begin
      n_err++; $display("FAIL mid_first: got %b/%h expected 1/00aa", dout_if.valid, dout_if.data);
    end
    dout_if.ready = 1'b1;
    step();
    dout_if.ready = 1'b0;
    n_vec++;
    if (dout_if.valid !== 1'b0) begin
      n_err++; $display("FAIL mid_after_read: got valid %b expected 0", dout_if.valid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
